// File: rtl/decode_scoreboard_if.sv
// Decode/fetch/writeback bundle for the decode-stage scoreboard.
// The master side drives decode and writeback fields; the slave side is the scoreboard.
interface decode_scoreboard_if;
  logic       dec_valid;
  logic [3:0] dec_ra;
  logic [3:0] dec_rb;
  logic [3:0] dec_rd;
  logic       dec_use_ra;
  logic       dec_use_rb;
  logic       dec_writes_rd;
  logic       dec_is_jump;
  logic [4:0] dec_jump_dest;
  logic       wb_valid;
  logic [3:0] wb_rd;
  logic       drain_req;
  logic       issue;
  logic       stall;
  logic       flush;
  logic       pc_load;
  logic [4:0] pc_target;
  logic [15:0] pending;
  logic [4:0] inflight;
  logic       drained;
  logic       err;

  modport master (
    output dec_valid, dec_ra, dec_rb, dec_rd, dec_use_ra, dec_use_rb,
           dec_writes_rd, dec_is_jump, dec_jump_dest, wb_valid, wb_rd, drain_req,
    input  issue, stall, flush, pc_load, pc_target, pending, inflight, drained, err
  );

  modport slave (
    input  dec_valid, dec_ra, dec_rb, dec_rd, dec_use_ra, dec_use_rb,
           dec_writes_rd, dec_is_jump, dec_jump_dest, wb_valid, wb_rd, drain_req,
    output issue, stall, flush, pc_load, pc_target, pending, inflight, drained, err
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode-stage interlock: tracks in-flight register writes, issues or stalls each
// decoded instruction, and turns taken jumps into a PC load plus a timed flush.
module decode_scoreboard #(
  parameter int FLUSH_CYCLES = 1,
  parameter int R0_ZERO      = 0
) (
  input logic               clk,
  input logic               rst,
  decode_scoreboard_if.slave bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  inflight_q, inflight_d;
  logic        flush_q, flush_d;
  logic        pc_load_q, pc_load_d;
  logic [4:0]  pc_target_q, pc_target_d;
  logic        err_q, err_d;

  logic        hazard;
  logic        issue;
  logic        stall;
  logic        drained;
  logic        jump_go;
  logic [15:0] set_vec;
  logic [15:0] clr_vec;

  // r0 terms vanish entirely when r0 is hardwired to zero
  function automatic logic is_r0(input logic [3:0] addr);
    return (R0_ZERO != 0) && (addr == 4'd0);
  endfunction

  always_comb begin
    hazard = (bus.dec_use_ra    & pending_q[bus.dec_ra] & ~is_r0(bus.dec_ra))
           | (bus.dec_use_rb    & pending_q[bus.dec_rb] & ~is_r0(bus.dec_rb))
           | (bus.dec_writes_rd & pending_q[bus.dec_rd] & ~is_r0(bus.dec_rd));
  end

  // Output process: issue/stall/drained
  always_comb begin
    issue   = 1'b0;
    stall   = 1'b1;
    drained = 1'b0;
    if (!rst) begin
      if (state_q == RUN) begin
        issue   = bus.dec_valid & ~hazard & ~bus.drain_req;
        stall   = bus.dec_valid & ~issue;
        drained = bus.drain_req & (pending_q == 16'd0);
      end
    end
  end

  assign jump_go = issue & bus.dec_is_jump;

  // Next-state process
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (jump_go) begin
          state_d = FLUSH;
          fcnt_d  = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd0) state_d = RUN;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    set_vec = 16'd0;
    clr_vec = 16'd0;
    if (issue && bus.dec_writes_rd && !bus.dec_is_jump && !is_r0(bus.dec_rd))
      set_vec[bus.dec_rd] = 1'b1;
    if (bus.wb_valid)
      clr_vec[bus.wb_rd] = 1'b1;
    // Clear wins over a same-cycle set; that bit was necessarily idle, so err fires too
    pending_d = (pending_q | set_vec) & ~clr_vec;
    err_d     = err_q | (bus.wb_valid & ~pending_q[bus.wb_rd]);
    inflight_d = 5'd0;
    for (int i = 0; i < 16; i++)
      inflight_d = inflight_d + 5'(pending_d[i]);
    flush_d     = (state_d == FLUSH);
    pc_load_d   = jump_go;
    pc_target_d = jump_go ? bus.dec_jump_dest : pc_target_q;
  end

  // State register process
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      pending_q   <= 16'd0;
      inflight_q  <= 5'd0;
      flush_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_target_q <= 5'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      flush_q     <= flush_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      err_q       <= err_d;
    end
  end

  assign bus.issue     = issue;
  assign bus.stall     = stall;
  assign bus.drained   = drained;
  assign bus.flush     = flush_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_target = pc_target_q;
  assign bus.pending   = pending_q;
  assign bus.inflight  = inflight_q;
  assign bus.err       = err_q;

endmodule
